// File: rtl/apb_svc_pkg.sv
// Shared definitions for the APB vectored service unit: register offsets,
// request FSM states and the channel-ID width helper.
package apb_svc_pkg;

  // Byte offsets inside the slave window (decoded on PADDR[4:2]).
  localparam logic [4:0] OFS_MASK    = 5'h00;
  localparam logic [4:0] OFS_PENDING = 5'h04;
  localparam logic [4:0] OFS_SET     = 5'h08;
  localparam logic [4:0] OFS_CLEAR   = 5'h0C;
  localparam logic [4:0] OFS_MODE    = 5'h10;
  localparam logic [4:0] OFS_STATUS  = 5'h14;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } svc_state_e;

  // Channel-ID width; never narrower than one bit so a single channel still has an ID.
  function automatic int svc_id_width(input int num_ch);
    if (num_ch <= 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(num_ch);
    end
  endfunction

endpackage

// File: rtl/svc_sync_edge.sv
// Per-channel input conditioning: optional synchroniser chain followed by a
// history flop used to detect 0->1 transitions of the synchronised level.
module svc_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic signal_i,
  output logic level_o,
  output logic rise_o
);

  logic hist_r;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign level_o = signal_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_r;

      // Shift the raw line through the synchroniser chain.
      always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
          sync_r <= '0;
        end else begin
          sync_r[0] <= signal_i;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
          end
        end
      end

      assign level_o = sync_r[SYNC_STAGES-1];
    end
  endgenerate

  // Remember last cycle's synchronised level for rise detection.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hist_r <= 1'b0;
    end else begin
      hist_r <= level_o;
    end
  end

  assign rise_o = level_o & ~hist_r;

endmodule

// File: rtl/apb_vectored_service_unit.sv
// APB event service unit: latches per-channel pending events, masks them and
// presents the lowest-indexed active channel as a vectored request with ack.
module apb_vectored_service_unit
  import apb_svc_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_CH         = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int ID_W           = svc_id_width(NUM_CH)
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_CH-1:0]         signal_i,
  output logic                      irq_req_o,
  output logic [ID_W-1:0]           irq_id_o,
  input  logic                      irq_ack_i,
  input  logic [ID_W-1:0]           irq_ack_id_i
);

  logic [NUM_CH-1:0] mask_r, pending_r, mode_r;
  logic [NUM_CH-1:0] level_s, rise_s, set_s, clr_s, pending_nxt_s, active_s;
  logic [NUM_CH-1:0] wdata_s;
  logic [ID_W-1:0]   id_r, win_id_s;
  logic              req_r, any_s, id_pend_s, ack_match_s;
  logic              access_s, wr_s, rd_s;
  logic [4:0]        ofs_s;
  logic [31:0]       rdata_s;
  svc_state_e        state_r;
  logic              unused_addr_s;

  assign access_s      = PSEL & PENABLE;
  assign wr_s          = access_s & PWRITE;
  assign rd_s          = access_s & ~PWRITE;
  assign ofs_s         = {PADDR[4:2], 2'b00};
  assign wdata_s       = PWDATA[NUM_CH-1:0];
  assign unused_addr_s = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      svc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .signal_i(signal_i[g]),
        .level_o (level_s[g]),
        .rise_o  (rise_s[g])
      );
    end
  endgenerate

  assign ack_match_s = (state_r == REQ) & irq_ack_i & (irq_ack_id_i == id_r);

  // Next pending value: register write beats set sources, which beat clears.
  always_comb begin
    set_s = (mode_r & rise_s) | (~mode_r & level_s);
    clr_s = '0;
    if (wr_s && (ofs_s == OFS_SET)) begin
      set_s = set_s | wdata_s;
    end else begin
      set_s = set_s;
    end
    if (wr_s && (ofs_s == OFS_CLEAR)) begin
      clr_s = wdata_s;
    end else begin
      clr_s = '0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      clr_s[i] = clr_s[i] | (ack_match_s && (id_r == ID_W'(i)));
    end
    if (wr_s && (ofs_s == OFS_PENDING)) begin
      pending_nxt_s = wdata_s;
    end else begin
      pending_nxt_s = (pending_r & ~clr_s) | set_s;
    end
  end

  // Priority encoder: lowest-indexed active channel wins; also look up pending[id].
  always_comb begin
    active_s  = pending_r & mask_r;
    win_id_s  = '0;
    id_pend_s = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (active_s[i]) begin
        win_id_s = ID_W'(i);
      end else begin
        win_id_s = win_id_s;
      end
      id_pend_s = id_pend_s | (pending_r[i] & (id_r == ID_W'(i)));
    end
  end

  assign any_s = |active_s;

  // Configuration and pending registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mask_r    <= '0;
      mode_r    <= '0;
      pending_r <= '0;
    end else begin
      if (wr_s && (ofs_s == OFS_MASK)) begin
        mask_r <= wdata_s;
      end
      if (wr_s && (ofs_s == OFS_MODE)) begin
        mode_r <= wdata_s;
      end
      pending_r <= pending_nxt_s;
    end
  end

  // Request FSM: latch winner, hold ID until matched ack or withdrawal.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= IDLE;
      req_r   <= 1'b0;
      id_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            id_r    <= win_id_s;
            req_r   <= 1'b1;
            state_r <= REQ;
          end
        end
        REQ: begin
          if (ack_match_s || !id_pend_s) begin
            req_r   <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          req_r   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Read mux on current register state; zero outside a read access phase.
  always_comb begin
    rdata_s = '0;
    if (rd_s) begin
      case (ofs_s)
        OFS_MASK:    rdata_s = 32'(mask_r);
        OFS_PENDING: rdata_s = 32'(pending_r);
        OFS_MODE:    rdata_s = 32'(mode_r);
        OFS_STATUS: begin
          rdata_s[31]       = req_r;
          rdata_s[ID_W-1:0] = id_r;
        end
        default:     rdata_s = '0;
      endcase
    end else begin
      rdata_s = '0;
    end
  end

  assign PRDATA    = rdata_s;
  assign PREADY    = 1'b1;
  assign PSLVERR   = access_s & (PADDR[4:3] == 2'b11);
  assign irq_req_o = req_r;
  assign irq_id_o  = id_r;

endmodule
